// File: rtl/stage2_bias_relu_pool.sv
// stage2_bias_relu_pool
// Post-convolution stage of CNN layer 2: per-channel bias add, ReLU with
// saturation, then 2x2 stride-2 max pooling using a half-width line buffer.
//
// Handshake: a beat is taken on every rising edge where i_in_valid=1 (there
// is no ready; the upstream accumulator bank never stalls). o_ot_valid is a
// single-cycle pulse that qualifies o_ot_fmap; o_ot_fmap holds its value
// between pulses. o_frame_done pulses together with the last pooled pixel.
//
// Pipeline (fixed 2-cycle latency from the accepting edge to o_ot_valid):
//   edge t   : stage A registers the saturated value q and its position
//   edge t+1 : stage B1 keeps the even-column value in h, or forms the
//              horizontal pair max hm for an odd column
//   edge t+2 : stage B2 parks hm in the line buffer (even row) or merges it
//              with the line buffer entry and emits the pooled pixel (odd row)
module stage2_bias_relu_pool #(
  parameter int CO     = 3,
  parameter int ACI_BW = 24,
  parameter int B_BW   = 16,
  parameter int O_BW   = 16,
  parameter int W      = 8,
  parameter int H      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_in_valid,
  input  logic [CO*ACI_BW-1:0] i_in_acc,
  input  logic [CO*B_BW-1:0]   i_bias,
  output logic                 o_ot_valid,
  output logic [CO*O_BW-1:0]   o_ot_fmap,
  output logic                 o_frame_done
);

  // Column counter is at least 2 bits so col[CW-1:1] always indexes the
  // W/2-entry line buffer (W is even and at least 4).
  localparam int CW = (W > 2) ? $clog2(W) : 2;
  localparam int RW = (H > 2) ? $clog2(H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

  // Largest positive output value, at output width and at accumulator width
  // for the saturation compare.
  localparam logic [O_BW-1:0]   SAT_O    = {1'b0, {(O_BW-1){1'b1}}};
  localparam logic [ACI_BW-1:0] SAT_WIDE = {{(ACI_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};

  // ---------------------------------------------------------------------
  // Shared control path
  // ---------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          va;
  logic [CW-1:0] col_a;
  logic [RW-1:0] row_a;

  logic          vb;
  logic [CW-1:0] col_b;
  logic [RW-1:0] row_b;

  logic pair_b;
  logic lb_we;
  logic out_fire;
  logic last_b;

  // A valid odd-column beat in B2 closes a horizontal pair; the row parity
  // decides whether it is parked or merged into an output.
  assign pair_b   = vb & col_b[0];
  assign lb_we    = pair_b & ~row_b[0];
  assign out_fire = pair_b & row_b[0] & ~i_clear;
  assign last_b   = (row_b == ROW_LAST) && (col_b == COL_LAST);

  // Raster position of the next accepted beat; clear drops the current beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else if (i_clear) begin
      col <= '0;
      row <= '0;
    end else if (i_in_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Stage A control: valid and position travel alongside the saturated data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      va    <= 1'b0;
      col_a <= '0;
      row_a <= '0;
    end else begin
      va    <= i_in_valid & ~i_clear;
      col_a <= col;
      row_a <= row;
    end
  end

  // Stage B1 control: pure delay of the stage A control.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vb    <= 1'b0;
      col_b <= '0;
      row_b <= '0;
    end else begin
      vb    <= va & ~i_clear;
      col_b <= col_a;
      row_b <= row_a;
    end
  end

  // Output strobes: one pulse per completed window, frame_done on the last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_ot_valid   <= out_fire;
      o_frame_done <= out_fire & last_b;
    end
  end

  // ---------------------------------------------------------------------
  // Per-channel datapath
  // ---------------------------------------------------------------------
  for (genvar c = 0; c < CO; c++) begin : g_ch
    logic [ACI_BW-1:0] acc_c;
    logic [B_BW-1:0]   bias_c;
    logic [ACI_BW:0]   sum;
    logic [O_BW-1:0]   q_d;
    logic [O_BW-1:0]   qa;
    logic [O_BW-1:0]   h;
    logic [O_BW-1:0]   hm_d;
    logic [O_BW-1:0]   hm_r;
    logic [O_BW-1:0]   lb_rd;
    logic [O_BW-1:0]   pooled;
    logic [O_BW-1:0]   fmap_r;
    logic [O_BW-1:0]   linebuf [W/2];

    assign acc_c  = i_in_acc[c*ACI_BW +: ACI_BW];
    assign bias_c = i_bias[c*B_BW +: B_BW];

    // Bias add one bit wider than the accumulator so it can never wrap.
    always_comb begin
      sum = {acc_c[ACI_BW-1], acc_c}
          + {{(ACI_BW+1-B_BW){bias_c[B_BW-1]}}, bias_c};
    end

    // ReLU then clamp to the largest positive output value.
    always_comb begin
      q_d = sum[O_BW-1:0];
      if (sum[ACI_BW]) begin
        q_d = '0;
      end else if (sum[ACI_BW-1:0] > SAT_WIDE) begin
        q_d = SAT_O;
      end
    end

    // Stage A data register; holds across input gaps.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        qa <= '0;
      end else if (i_in_valid) begin
        qa <= q_d;
      end
    end

    assign hm_d = (qa > h) ? qa : h;

    // Stage B1: even column parks in h, odd column forms the pair max.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        h    <= '0;
        hm_r <= '0;
      end else if (va) begin
        if (col_a[0]) begin
          hm_r <= hm_d;
        end else begin
          h <= qa;
        end
      end
    end

    // Line buffer: one pair max per window column, written on even rows and
    // always rewritten before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
      if (lb_we) begin
        linebuf[col_b[CW-1:1]] <= hm_r;
      end
    end

    assign lb_rd  = linebuf[col_b[CW-1:1]];
    assign pooled = (lb_rd > hm_r) ? lb_rd : hm_r;

    // Pooled output register; holds its value between pulses.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fmap_r <= '0;
      end else if (out_fire) begin
        fmap_r <= pooled;
      end
    end

    assign o_ot_fmap[c*O_BW +: O_BW] = fmap_r;
  end

endmodule

// File: tb/tb_stage2_bias_relu_pool.sv
// tb_stage2_bias_relu_pool
// Directed bench for stage2_bias_relu_pool on a 4x4 map with 3 channels.
// Expected pooled pixels are hand-computed and queued before each frame; a
// negedge monitor pops them in order and also checks the 2-cycle latency.
module tb_stage2_bias_relu_pool;

  localparam int CO     = 3;
  localparam int ACI_BW = 24;
  localparam int B_BW   = 16;
  localparam int O_BW   = 16;
  localparam int W      = 4;
  localparam int H      = 4;
  localparam int AW     = CO*ACI_BW;
  localparam int BW     = CO*B_BW;
  localparam int OW     = CO*O_BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_clear;
  logic          i_in_valid;
  logic [AW-1:0] i_in_acc;
  logic [BW-1:0] i_bias;
  logic          o_ot_valid;
  logic [OW-1:0] o_ot_fmap;
  logic          o_frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Scoreboard: {frame_done, fmap} and the cycle each output is due.
  logic [OW:0] exp_q[$];
  int          t_q[$];

  logic [AW-1:0] fr [H][W];

  stage2_bias_relu_pool #(
    .CO(CO), .ACI_BW(ACI_BW), .B_BW(B_BW), .O_BW(O_BW), .W(W), .H(H)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (i_clear),
    .i_in_valid   (i_in_valid),
    .i_in_acc     (i_in_acc),
    .i_bias       (i_bias),
    .o_ot_valid   (o_ot_valid),
    .o_ot_fmap    (o_ot_fmap),
    .o_frame_done (o_frame_done)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] pa(input logic [23:0] a0, input logic [23:0] a1, input logic [23:0] a2);
    return {a2, a1, a0};
  endfunction

  function automatic logic [OW-1:0] po(input logic [15:0] o0, input logic [15:0] o1, input logic [15:0] o2);
    return {o2, o1, o0};
  endfunction

  function automatic logic [BW-1:0] pb(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2);
    return {b2, b1, b0};
  endfunction

  task automatic push_exp(input logic [OW-1:0] v, input logic done);
    exp_q.push_back({done, v});
  endtask

  task automatic load_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = pa(24'(16*r + c), 24'(16*r + c), 24'(16*r + c));
  endtask

  task automatic push_ramp_exp();
    push_exp(po(16'd17, 16'd17, 16'd17), 1'b0);
    push_exp(po(16'd19, 16'd19, 16'd19), 1'b0);
    push_exp(po(16'd49, 16'd49, 16'd49), 1'b0);
    push_exp(po(16'd51, 16'd51, 16'd51), 1'b1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      i_in_valid = 1'b0;
      i_clear    = 1'b0;
    end
  endtask

  // One beat at raster position (r,c), preceded by 'gap' idle cycles.
  task automatic send(input logic [AW-1:0] acc, input int r, input int c, input int gap, input logic clr);
    idle(gap);
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_acc   = acc;
    i_clear    = clr;
    if (!clr && (r % 2 == 1) && (c % 2 == 1)) t_q.push_back(cyc + 3);
  endtask

  task automatic run_frame(input int gap_max);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send(fr[r][c], r, c, (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0, 1'b0);
  endtask

  task automatic wait_drain(input string tag);
    idle(1);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    idle(4);
    check({"drain ", tag}, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (o_frame_done && !o_ot_valid) check("done_without_valid", 64'd1, 64'd0);
      if (o_ot_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_output", 64'(o_ot_fmap), 64'd0);
        end else begin
          logic [OW:0] e;
          int          t;
          e = exp_q.pop_front();
          t = (t_q.size() != 0) ? t_q.pop_front() : -1;
          check("fmap", 64'(o_ot_fmap), 64'(e[OW-1:0]));
          check("frame_done", 64'(o_frame_done), 64'(e[OW]));
          check("latency", 64'(cyc), 64'(t));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset      = 1'b1;
    i_clear    = 1'b0;
    i_in_valid = 1'b0;
    i_in_acc   = '0;
    i_bias     = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 64'(o_ot_valid), 64'd0);
    check("reset_fmap", 64'(o_ot_fmap), 64'd0);
    check("reset_done", 64'(o_frame_done), 64'd0);
    reset = 1'b0;
    idle(2);

    // Ramp, bias 0: window maxima 17, 19, 49, 51.
    load_ramp();
    i_bias = '0;
    push_ramp_exp();
    run_frame(0);
    wait_drain("ramp");

    // ReLU / saturation: ch0,ch1 bias -100, ch2 bias -32768.
    i_bias = pb(16'hFF9C, 16'hFF9C, 16'h8000);
    fr[0][0] = pa(24'd50, 24'd50, 24'd50);
    fr[0][1] = pa(24'd99, 24'd99, 24'd99);
    fr[1][0] = pa(24'd100, 24'd100, 24'd100);
    fr[1][1] = pa(24'd20, 24'd20, 24'd20);
    fr[0][2] = pa(24'd40000, 24'd40000, 24'd40000);
    fr[0][3] = '0;
    fr[1][2] = '0;
    fr[1][3] = '0;
    for (int r = 2; r < 4; r++) begin
      fr[r][0] = pa(24'h800000, 24'h800000, 24'h800000);
      fr[r][1] = pa(24'h800000, 24'h800000, 24'h800000);
      fr[r][2] = pa(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
      fr[r][3] = pa(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    end
    push_exp(po(16'd0, 16'd0, 16'd0), 1'b0);
    push_exp(po(16'd32767, 16'd32767, 16'd7232), 1'b0);
    push_exp(po(16'd0, 16'd0, 16'd0), 1'b0);
    push_exp(po(16'd32767, 16'd32767, 16'd32767), 1'b1);
    run_frame(0);
    wait_drain("relu_sat");

    // Per-channel independence and packing: biases {+5, 0, -5}.
    i_bias = pb(16'd5, 16'd0, 16'hFFFB);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        fr[r][c] = '0;
    fr[0][0] = pa(24'd1, 24'd1, 24'd1);
    fr[0][1] = pa(24'd2, 24'd2, 24'd2);
    fr[1][0] = pa(24'd3, 24'd3, 24'd3);
    fr[1][1] = pa(24'd4, 24'd4, 24'd4);
    for (int r = 0; r < 2; r++)
      for (int c = 2; c < 4; c++)
        fr[r][c] = pa(24'd10, 24'd20, 24'd30);
    push_exp(po(16'd9, 16'd4, 16'd0), 1'b0);
    push_exp(po(16'd15, 16'd20, 16'd25), 1'b0);
    push_exp(po(16'd5, 16'd0, 16'd0), 1'b0);
    push_exp(po(16'd5, 16'd0, 16'd0), 1'b1);
    run_frame(0);
    wait_drain("channels");

    // Ramp with 0-3 idle cycles before every beat.
    i_bias = '0;
    load_ramp();
    push_ramp_exp();
    run_frame(3);
    wait_drain("bubbles");

    // Clear together with beat (2,1), then a full restart from (0,0).
    load_ramp();
    push_exp(po(16'd17, 16'd17, 16'd17), 1'b0);
    push_exp(po(16'd19, 16'd19, 16'd19), 1'b0);
    push_ramp_exp();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < W; c++)
        send(fr[r][c], r, c, 0, 1'b0);
    send(fr[2][0], 2, 0, 0, 1'b0);
    send(fr[2][1], 2, 1, 3, 1'b1);
    run_frame(0);
    wait_drain("clear");

    // Back-to-back frames, async reset at (1,2) of the second, third frame clean.
    load_ramp();
    push_ramp_exp();
    run_frame(0);
    for (int c = 0; c < W; c++) send(fr[0][c], 0, c, 0, 1'b0);
    send(fr[1][0], 1, 0, 0, 1'b0);
    send(fr[1][1], 1, 1, 0, 1'b0);
    send(fr[1][2], 1, 2, 0, 1'b0);
    #1;
    check("frame1_consumed", 64'(exp_q.size()), 64'd0);
    check("pre_reset_fmap", 64'(o_ot_fmap), 64'(po(16'd51, 16'd51, 16'd51)));
    reset      = 1'b1;
    i_in_valid = 1'b0;
    #1;
    check("async_reset_valid", 64'(o_ot_valid), 64'd0);
    check("async_reset_fmap", 64'(o_ot_fmap), 64'd0);
    check("async_reset_done", 64'(o_frame_done), 64'd0);
    exp_q.delete();
    t_q.delete();
    idle(2);
    reset = 1'b0;
    idle(1);
    push_ramp_exp();
    run_frame(0);
    wait_drain("after_reset");

    check("latency_queue_empty", 64'(t_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stage2_bias_relu_pool.md
# stage2_bias_relu_pool

Post-convolution stage for the second CNN layer. It consumes the per-output-channel input-channel-accumulated sums produced by the stage-2 CI accumulator bank, one raster-ordered feature-map pixel per valid beat. Per channel it adds bias, applies ReLU with saturation, and performs 2x2 stride-2 max pooling through an internal half-width line buffer. It emits one pooled pixel (all channels in parallel) per completed 2x2 window, feeding the stage-3 / flatten input.

## Interface
- `CO`, 3, output channels processed in parallel
- `ACI_BW`, 24, signed width of each accumulated input sum
- `B_BW`, 16, signed bias width (B_BW <= ACI_BW)
- `O_BW`, 16, output width per channel; value range 0 .. 2^(O_BW-1)-1
- `W`, 8, conv output width in pixels; must be even
- `H`, 8, conv output height in pixels; must be even

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `i_clear`  in  1  synchronous frame abort / restart
- `i_in_valid`  in  1  one pixel beat; no backpressure
- `i_in_acc`  in  CO*ACI_BW  signed sums; channel c at [c*ACI_BW +: ACI_BW]
- `i_bias`  in  CO*B_BW  signed biases, same packing; static for the whole frame
- `o_ot_valid`  out  1  pooled pixel valid, 1-cycle pulse
- `o_ot_fmap`  out  CO*O_BW  pooled pixel, same packing
- `o_frame_done`  out  1  asserted together with the last pooled pixel of a frame

## Operation
- Input counters `col` (0..W-1) and `row` (0..H-1) advance only on accepted beats.
  - `col` wraps to 0 at W-1 and `row` increments.
  - At (H-1, W-1), both wrap to 0.
- Stage A (registered), per channel:
  - s = sign-extend(acc) + sign-extend(bias), computed at ACI_BW+1 bits so the add cannot overflow.
  - r = (s < 0) ? 0 : s.
  - q = min(r, 2^(O_BW-1)-1).
  - `col`, `row` and valid are registered alongside q.
- Stage B, pooling, per channel, acting on the Stage A output:
  - Even col: hold register h <= q.
  - Odd col: hm = max(h, q).
  - Even row with odd col: linebuf[col>>1] <= hm (linebuf has W/2 entries per channel).
  - Odd row with odd col: o_ot_fmap <= max(linebuf[col>>1], hm), and o_ot_valid pulses.
- All comparisons are unsigned on O_BW bits; values are non-negative after ReLU.
- Gaps between beats are allowed anywhere, including inside a window. State is held across gaps.
- `i_clear`:
  - Zeroes `col`, `row`, the Stage A/B valids and `o_ot_valid`.
  - Linebuf and h contents are don't-care, because they are always overwritten before being read.
  - If `i_clear` and `i_in_valid` are high in the same cycle, clear wins and that beat is dropped.

## Timing
- Reset values: `o_ot_valid`=0, `o_ot_fmap`=0, `o_frame_done`=0. All counters and pipeline valids are 0.
- Latency: an accepted beat at (odd row, odd col) on edge t produces `o_ot_valid`=1 during the cycle after edge t+2, i.e. a fixed 2-cycle latency.
- `o_ot_fmap` holds its last value while `o_ot_valid`=0.
- Throughput: one beat per cycle sustained. Output is produced on W/2 beats of every odd row, giving (W/2)*(H/2) outputs per frame.
- `o_frame_done` is high exactly on the cycle carrying the pooled pixel from input (H-1, W-1).
- Back-to-back frames need no idle cycle: pixel (0,0) of the next frame may arrive on the cycle right after (H-1, W-1).
- `reset` asserted mid-frame: outputs drop to 0 asynchronously. After deassertion the next beat is treated as (0,0).
- A clear on the cycle a pooled result sits in Stage B suppresses that output.

## Test plan
- Ramp, W=H=4, CO=1, bias=0, acc = 16*row + col:
  - Expect 4 outputs: 17, 19, 49, 51.
  - `o_frame_done` is high only with 51.
  - Each output appears 2 cycles after its input (1,1), (1,3), (3,1), (3,3).
- ReLU and saturation, O_BW=16, bias=-100:
  - Window {50, 99, 100, 20} -> 0.
  - Window {40000, 0, 0, 0} -> 32767.
  - acc = -2^23 with bias = -2^15 -> 0, with no wraparound.
- Per-channel independence, CO=3:
  - Distinct biases {+5, 0, -5} on identical data {1, 2, 3, 4} -> outputs {9, 4, 0}.
  - Check that the packing order is correct.
- Bubbles: randomly deassert `i_in_valid` 0-3 cycles between beats of the ramp test -> identical output values and count.
- Clear mid-frame: assert `i_clear` together with a beat at (2,1), then restart the ramp from (0,0) -> no stale output, and a full correct frame of 4 outputs.
- Back-to-back frames plus async `reset` asserted at (1,2) of the second frame -> all outputs 0 immediately, and the third frame is correct.
